// File: rtl/arcade_input_ctrl.sv
// Player-input front end: merges PS/2 key events and hps_io joystick words into per-player controls, coin pulses and pause.
// Latency: joystick/cabinet -> outputs 1 cycle, ps2_key -> outputs 2 cycles (key-state reg + output reg).
// Backpressure: none; every input is sampled each clk_sys cycle. Optional INPUT_SOCD_EN clears opposing directions.
module arcade_input_ctrl #(
  parameter int PLAYERS  = 2,
  parameter int BUTTONS  = 4,
  parameter int COIN_MIN = 54080,
  parameter int COIN_GAP = 54080
) (
  input  logic                         clk_sys,
  input  logic                         reset_n,
  input  logic [10:0]                  ps2_key,
  input  logic [16*PLAYERS-1:0]        joy,
  input  logic                         cabinet,
  output logic [4*PLAYERS-1:0]         p_dir,
  output logic [BUTTONS*PLAYERS-1:0]   p_fire,
  output logic [PLAYERS-1:0]           p_start,
  output logic [1:0]                   coin,
  output logic                         pause_req
);

  localparam int CNT_MAX = (COIN_MIN > COIN_GAP) ? COIN_MIN : COIN_GAP;
  localparam int CW      = $clog2(CNT_MAX + 1);
  localparam logic [CW-1:0] MIN_LAST = CW'(COIN_MIN - 1);
  localparam logic [CW-1:0] GAP_LAST = CW'(COIN_GAP - 1);
  // Coin slot 1 only has a joystick source when a second player word exists.
  localparam int C1_BIT = (PLAYERS > 1) ? 24 : 8;

  typedef enum logic [1:0] {C_IDLE, C_PULSE, C_HOLD, C_GAP} coin_state_t;

  // Key-state bits: [3:0] P1 up/down/left/right, [7:4] P1 fire0-3, [11:8] P2 dirs,
  // [15:12] P2 fire0-3, [17:16] P1 start, [19:18] P2 start, [21:20] coin0, [22] coin1, [23] pause.
  logic [23:0]                key_st;
  logic                       key_tog;
  logic                       key_hit;
  logic [4:0]                 key_idx;
  logic [3:0]                 raw_dir  [PLAYERS];
  logic [BUTTONS-1:0]         raw_fire [PLAYERS];
  logic [PLAYERS-1:0]         raw_start;
  logic                       pause_press;
  logic                       press_q;
  logic [3:0]                 sel_dir;
  logic [4*PLAYERS-1:0]       dir_n;
  logic [BUTTONS*PLAYERS-1:0] fire_n;
  logic [1:0]                 coin_raw;
  logic [1:0]                 coin_n;
  coin_state_t                c_st     [2];
  coin_state_t                c_st_n   [2];
  logic [CW-1:0]              c_cnt    [2];
  logic [CW-1:0]              c_cnt_n  [2];
  logic                       unused_inputs;

  assign unused_inputs = ^{joy, ps2_key[8]};

  // Map the event scan code onto a key-state bit; extended prefix is deliberately ignored.
  always_comb begin
    key_hit = 1'b1;
    key_idx = 5'd0;
    case (ps2_key[7:0])
      8'h75: key_idx = 5'd0;
      8'h72: key_idx = 5'd1;
      8'h6B: key_idx = 5'd2;
      8'h74: key_idx = 5'd3;
      8'h14: key_idx = 5'd4;
      8'h11: key_idx = 5'd5;
      8'h29: key_idx = 5'd6;
      8'h12: key_idx = 5'd7;
      8'h2D: key_idx = 5'd8;
      8'h2B: key_idx = 5'd9;
      8'h23: key_idx = 5'd10;
      8'h34: key_idx = 5'd11;
      8'h1C: key_idx = 5'd12;
      8'h1B: key_idx = 5'd13;
      8'h21: key_idx = 5'd14;
      8'h1D: key_idx = 5'd15;
      8'h05: key_idx = 5'd16;
      8'h16: key_idx = 5'd17;
      8'h06: key_idx = 5'd18;
      8'h1E: key_idx = 5'd19;
      8'h76: key_idx = 5'd20;
      8'h2E: key_idx = 5'd21;
      8'h36: key_idx = 5'd22;
      8'h4D: key_idx = 5'd23;
      default: key_hit = 1'b0;
    endcase
  end

  // Track the event toggle and latch pressed/released for mapped keys; reset resyncs the tracker.
  always_ff @(posedge clk_sys) begin
    if (!reset_n) begin
      key_tog <= ps2_key[10];
      key_st  <= '0;
    end else if (ps2_key[10] != key_tog) begin
      key_tog <= ps2_key[10];
      if (key_hit) key_st[key_idx] <= ps2_key[9];
    end
  end

  // OR keyboard state with each player's joystick word; players 3-4 are joystick-only.
  always_comb begin
    raw_start   = '0;
    pause_press = key_st[23];
    for (int p = 0; p < PLAYERS; p++) begin
      raw_dir[p] = joy[16*p +: 4];
      for (int b = 0; b < BUTTONS; b++) raw_fire[p][b] = joy[16*p + 4 + b];
      raw_start[p] = joy[16*p + 6];
      pause_press  = pause_press | joy[16*p + 9];
      if (p == 0) begin
        raw_dir[p]   = raw_dir[p] | {key_st[0], key_st[1], key_st[2], key_st[3]};
        for (int b = 0; b < BUTTONS; b++) raw_fire[p][b] = raw_fire[p][b] | key_st[4 + b];
        raw_start[p] = raw_start[p] | key_st[16] | key_st[17];
      end else if (p == 1) begin
        raw_dir[p]   = raw_dir[p] | {key_st[8], key_st[9], key_st[10], key_st[11]};
        for (int b = 0; b < BUTTONS; b++) raw_fire[p][b] = raw_fire[p][b] | key_st[12 + b];
        raw_start[p] = raw_start[p] | key_st[18] | key_st[19];
      end
    end
  end

  // Upright cabinets share player 0's stick and buttons; starts always stay per player.
  always_comb begin
    dir_n   = '0;
    fire_n  = '0;
    sel_dir = '0;
    for (int p = 0; p < PLAYERS; p++) begin
      sel_dir = (cabinet || p == 0) ? raw_dir[p] : raw_dir[0];
`ifdef INPUT_SOCD_EN
      if (sel_dir[1] && sel_dir[0]) sel_dir[1:0] = 2'b00;
      if (sel_dir[3] && sel_dir[2]) sel_dir[3:2] = 2'b00;
`endif
      dir_n[4*p +: 4]             = sel_dir;
      fire_n[BUTTONS*p +: BUTTONS] = (cabinet || p == 0) ? raw_fire[p] : raw_fire[0];
    end
  end

  // Register player outputs and toggle pause on each rising edge of the combined press.
  always_ff @(posedge clk_sys) begin
    if (!reset_n) begin
      p_dir     <= '0;
      p_fire    <= '0;
      p_start   <= '0;
      press_q   <= 1'b0;
      pause_req <= 1'b0;
    end else begin
      p_dir   <= dir_n;
      p_fire  <= fire_n;
      p_start <= raw_start;
      press_q <= pause_press;
      if (pause_press && !press_q) pause_req <= ~pause_req;
    end
  end

  assign coin_raw[0] = key_st[20] | key_st[21] | joy[8];
  assign coin_raw[1] = key_st[22] | ((PLAYERS > 1) && joy[C1_BIT]);

  // Coin shaper state and registered pulse output.
  always_ff @(posedge clk_sys) begin
    if (!reset_n) begin
      for (int s = 0; s < 2; s++) begin
        c_st[s]  <= C_IDLE;
        c_cnt[s] <= '0;
      end
      coin <= '0;
    end else begin
      for (int s = 0; s < 2; s++) begin
        c_st[s]  <= c_st_n[s];
        c_cnt[s] <= c_cnt_n[s];
      end
      coin <= coin_n;
    end
  end

  // Stretch short coin presses to COIN_MIN, follow long ones, then blank for COIN_GAP.
  always_comb begin
    coin_n = '0;
    for (int s = 0; s < 2; s++) begin
      c_st_n[s]  = c_st[s];
      c_cnt_n[s] = c_cnt[s];
      case (c_st[s])
        C_IDLE: begin
          if (coin_raw[s]) begin
            c_st_n[s]  = C_PULSE;
            c_cnt_n[s] = '0;
            coin_n[s]  = 1'b1;
          end
        end
        C_PULSE: begin
          coin_n[s] = 1'b1;
          if (c_cnt[s] == MIN_LAST) begin
            // Minimum width reached: keep following the input or release now.
            if (coin_raw[s]) begin
              c_st_n[s] = C_HOLD;
            end else begin
              c_st_n[s]  = C_GAP;
              c_cnt_n[s] = '0;
              coin_n[s]  = 1'b0;
            end
          end else begin
            c_cnt_n[s] = c_cnt[s] + CW'(1);
          end
        end
        C_HOLD: begin
          if (coin_raw[s]) begin
            coin_n[s] = 1'b1;
          end else begin
            c_st_n[s]  = C_GAP;
            c_cnt_n[s] = '0;
          end
        end
        default: begin
          if (c_cnt[s] == GAP_LAST) c_st_n[s] = C_IDLE;
          else                      c_cnt_n[s] = c_cnt[s] + CW'(1);
        end
      endcase
    end
  end

endmodule

// File: tb/tb_arcade_input_ctrl.sv
// Bench for arcade_input_ctrl: vector table, corner-case sequences and random stimulus vs a behavioural model.
// Latency: outputs sampled 1 time unit after each clk_sys edge.
// Backpressure: none; inputs are driven every cycle.
module tb_arcade_input_ctrl;
  localparam int PL   = 2;
  localparam int BT   = 4;
  localparam int CMIN = 8;
  localparam int CGAP = 4;

  logic        clk_sys = 1'b0;
  logic        reset_n;
  logic [10:0] ps2_key;
  logic [31:0] joy;
  logic        cabinet;
  logic [7:0]  p_dir;
  logic [7:0]  p_fire;
  logic [1:0]  p_start;
  logic [1:0]  coin;
  logic        pause_req;

  int n_chk  = 0;
  int n_pass = 0;

  always #5 clk_sys = ~clk_sys;

  arcade_input_ctrl #(.PLAYERS(PL), .BUTTONS(BT), .COIN_MIN(CMIN), .COIN_GAP(CGAP)) dut (
    .clk_sys(clk_sys), .reset_n(reset_n), .ps2_key(ps2_key), .joy(joy), .cabinet(cabinet),
    .p_dir(p_dir), .p_fire(p_fire), .p_start(p_start), .coin(coin), .pause_req(pause_req)
  );

  // Behavioural model: key up/down table per scan code, coin pulse age / gap countdown.
  bit         kd [256];
  bit         m_tog;
  logic [7:0] m_dir, m_fire;
  logic [1:0] m_start, m_coin;
  bit         m_pause, m_prev;
  bit         m_act [2];
  int         m_age [2];
  int         m_gap [2];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  task automatic model_edge();
    logic [3:0] rd [2];
    logic [3:0] rf [2];
    logic [1:0] c;
    bit press;
    if (!reset_n) begin
      for (int i = 0; i < 256; i++) kd[i] = 1'b0;
      m_tog = ps2_key[10];
      m_dir = '0; m_fire = '0; m_start = '0; m_coin = '0;
      m_pause = 1'b0; m_prev = 1'b0;
      for (int s = 0; s < 2; s++) begin m_act[s] = 1'b0; m_age[s] = 0; m_gap[s] = 0; end
    end else begin
      rd[0] = joy[3:0]   | {kd[8'h75], kd[8'h72], kd[8'h6B], kd[8'h74]};
      rd[1] = joy[19:16] | {kd[8'h2D], kd[8'h2B], kd[8'h23], kd[8'h34]};
      rf[0] = joy[7:4]   | {kd[8'h12], kd[8'h29], kd[8'h11], kd[8'h14]};
      rf[1] = joy[23:20] | {kd[8'h1D], kd[8'h21], kd[8'h1B], kd[8'h1C]};
      m_start[0] = joy[6]  | kd[8'h05] | kd[8'h16];
      m_start[1] = joy[22] | kd[8'h06] | kd[8'h1E];
      if (!cabinet) begin rd[1] = rd[0]; rf[1] = rf[0]; end
`ifdef INPUT_SOCD_EN
      for (int p = 0; p < 2; p++) begin
        if (rd[p][0] && rd[p][1]) rd[p][1:0] = 2'b00;
        if (rd[p][2] && rd[p][3]) rd[p][3:2] = 2'b00;
      end
`endif
      m_dir  = {rd[1], rd[0]};
      m_fire = {rf[1], rf[0]};
      c[0] = joy[8]  | kd[8'h76] | kd[8'h2E];
      c[1] = joy[24] | kd[8'h36];
      for (int s = 0; s < 2; s++) begin
        if (m_act[s]) begin
          m_age[s]++;
          if (m_age[s] >= CMIN && !c[s]) begin m_act[s] = 1'b0; m_gap[s] = CGAP; end
        end else if (m_gap[s] > 0) begin
          m_gap[s]--;
        end else if (c[s]) begin
          m_act[s] = 1'b1; m_age[s] = 0;
        end
        m_coin[s] = m_act[s];
      end
      press = kd[8'h4D] | joy[9] | joy[25];
      if (press && !m_prev) m_pause = !m_pause;
      m_prev = press;
      if (ps2_key[10] != m_tog) begin
        m_tog = ps2_key[10];
        kd[ps2_key[7:0]] = ps2_key[9];
      end
    end
  endtask

  task automatic step();
    model_edge();
    @(posedge clk_sys);
    #1;
    chk("m_dir",   32'(p_dir),     32'(m_dir));
    chk("m_fire",  32'(p_fire),    32'(m_fire));
    chk("m_start", 32'(p_start),   32'(m_start));
    chk("m_coin",  32'(coin),      32'(m_coin));
    chk("m_pause", 32'(pause_req), 32'(m_pause));
  endtask

  task automatic key_ev(input bit pr, input logic [8:0] code);
    ps2_key = {~ps2_key[10], pr, code};
  endtask

  task automatic coin_run(input int hold, input int tail, output int highs);
    highs = 0;
    joy[8] = 1'b1;
    for (int i = 0; i < hold; i++) begin step(); highs += int'(coin[0]); end
    joy[8] = 1'b0;
    for (int i = 0; i < tail; i++) begin step(); highs += int'(coin[0]); end
  endtask

  typedef struct {
    logic [31:0] joy;
    logic        cab;
    logic        ev;
    logic        pr;
    logic [8:0]  code;
    logic [7:0]  dir;
    logic [7:0]  fire;
    logic [1:0]  start;
  } vec_t;

  vec_t tbl [24];
  logic [7:0] codes [25];

  initial begin
    int hi;
    int changes;
    logic prev;
    tbl = '{
      '{32'h0, 1'b1, 1'b1, 1'b1, 9'h06B, 8'h00, 8'h00, 2'b00},
      '{32'h0, 1'b1, 1'b0, 1'b0, 9'h000, 8'h02, 8'h00, 2'b00},
      '{32'h0, 1'b1, 1'b1, 1'b0, 9'h06B, 8'h02, 8'h00, 2'b00},
      '{32'h0, 1'b1, 1'b0, 1'b0, 9'h000, 8'h00, 8'h00, 2'b00},
      '{32'h0, 1'b1, 1'b1, 1'b1, 9'h099, 8'h00, 8'h00, 2'b00},
      '{32'h0, 1'b1, 1'b0, 1'b0, 9'h000, 8'h00, 8'h00, 2'b00},
      '{32'h0041_0009, 1'b1, 1'b0, 1'b0, 9'h000, 8'h19, 8'h40, 2'b10},
      '{32'h0041_0009, 1'b0, 1'b0, 1'b0, 9'h000, 8'h99, 8'h00, 2'b10},
      '{32'h0, 1'b0, 1'b1, 1'b1, 9'h014, 8'h00, 8'h00, 2'b00},
      '{32'h0, 1'b0, 1'b0, 1'b0, 9'h000, 8'h00, 8'h11, 2'b00},
      '{32'h0, 1'b1, 1'b0, 1'b0, 9'h000, 8'h00, 8'h01, 2'b00},
      '{32'h0, 1'b1, 1'b1, 1'b1, 9'h01E, 8'h00, 8'h01, 2'b00},
      '{32'h0, 1'b1, 1'b0, 1'b0, 9'h000, 8'h00, 8'h01, 2'b10},
      '{32'h0, 1'b1, 1'b1, 1'b0, 9'h014, 8'h00, 8'h01, 2'b10},
      '{32'h0, 1'b1, 1'b1, 1'b0, 9'h01E, 8'h00, 8'h00, 2'b10},
      '{32'h0, 1'b1, 1'b0, 1'b0, 9'h000, 8'h00, 8'h00, 2'b00},
      '{32'h0, 1'b1, 1'b1, 1'b1, 9'h02D, 8'h00, 8'h00, 2'b00},
      '{32'h0, 1'b1, 1'b0, 1'b0, 9'h000, 8'h80, 8'h00, 2'b00},
      '{32'h0, 1'b0, 1'b0, 1'b0, 9'h000, 8'h00, 8'h00, 2'b00},
      '{32'h0, 1'b0, 1'b1, 1'b0, 9'h02D, 8'h00, 8'h00, 2'b00},
      '{32'h0, 1'b1, 1'b1, 1'b1, 9'h174, 8'h00, 8'h00, 2'b00},
      '{32'h0, 1'b1, 1'b0, 1'b0, 9'h000, 8'h01, 8'h00, 2'b00},
      '{32'h0, 1'b1, 1'b1, 1'b0, 9'h074, 8'h01, 8'h00, 2'b00},
      '{32'h0, 1'b1, 1'b0, 1'b0, 9'h000, 8'h00, 8'h00, 2'b00}
    };
    codes = '{8'h75, 8'h72, 8'h6B, 8'h74, 8'h14, 8'h11, 8'h29, 8'h12, 8'h2D, 8'h2B,
              8'h23, 8'h34, 8'h1C, 8'h1B, 8'h21, 8'h1D, 8'h05, 8'h16, 8'h06, 8'h1E,
              8'h76, 8'h2E, 8'h36, 8'h4D, 8'h99};

    // Reset with every joystick bit high: outputs must stay cleared.
    reset_n = 1'b0; ps2_key = '0; joy = '1; cabinet = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("rst_dir",   32'(p_dir),   32'h0);
      chk("rst_fire",  32'(p_fire),  32'h0);
      chk("rst_start", 32'(p_start), 32'h0);
      chk("rst_coin",  32'(coin),    32'h0);
      chk("rst_pause", 32'(pause_req), 32'h0);
    end
    reset_n = 1'b1;
    step();
`ifdef INPUT_SOCD_EN
    chk("rel_p1_dir", 32'(p_dir[3:0]), 32'h0);
`else
    chk("rel_p1_dir", 32'(p_dir[3:0]), 32'hF);
`endif
    joy = '0;
    for (int i = 0; i < 30; i++) step();

    // Vector table: key latency, unmapped/extended codes, cabinet merge.
    for (int i = 0; i < 24; i++) begin
      joy = tbl[i].joy;
      cabinet = tbl[i].cab;
      if (tbl[i].ev) key_ev(tbl[i].pr, tbl[i].code);
      step();
      chk($sformatf("tbl%0d_dir", i),   32'(p_dir),   32'(tbl[i].dir));
      chk($sformatf("tbl%0d_fire", i),  32'(p_fire),  32'(tbl[i].fire));
      chk($sformatf("tbl%0d_start", i), 32'(p_start), 32'(tbl[i].start));
    end
    joy = '0;
    for (int i = 0; i < 20; i++) step();

    // Coin shaping: glitch stretched, long press followed, press during gap ignored.
    coin_run(1, 30, hi);
    chk("coin_glitch_len", 32'(hi), 32'(CMIN));
    coin_run(20, 30, hi);
    chk("coin_held_len", 32'(hi), 32'd20);
    coin_run(1, 0, hi);
    for (int i = 0; i < 20; i++) begin
      if (coin[0] == 1'b0) break;
      step();
    end
    chk("coin_gap_fall", 32'(coin[0]), 32'h0);
    coin_run(1, 15, hi);
    chk("coin_gap_ignored", 32'(hi), 32'h0);

    // Reset in the middle of a pulse, input still held afterwards.
    joy[8] = 1'b1;
    step();
    chk("mid_start", 32'(coin[0]), 32'h1);
    step(); step();
    reset_n = 1'b0;
    step();
    chk("mid_rst_drop", 32'(coin[0]), 32'h0);
    reset_n = 1'b1;
    step();
    chk("mid_restart", 32'(coin[0]), 32'h1);
    joy[8] = 1'b0;
    hi = 1;
    for (int i = 0; i < 20; i++) begin step(); hi += int'(coin[0]); end
    chk("mid_full_len", 32'(hi), 32'(CMIN));

    // Pause: long hold on P2 toggles once, key press toggles back.
    reset_n = 1'b0; step();
    reset_n = 1'b1; step();
    chk("pause_init", 32'(pause_req), 32'h0);
    joy[25] = 1'b1;
    changes = 0;
    prev = pause_req;
    for (int i = 0; i < 100; i++) begin
      step();
      if (pause_req !== prev) changes++;
      prev = pause_req;
    end
    chk("pause_toggles", 32'(changes), 32'd1);
    chk("pause_on", 32'(pause_req), 32'h1);
    joy = '0;
    step();
    key_ev(1'b1, 9'h04D);
    step(); step(); step();
    chk("pause_key_off", 32'(pause_req), 32'h0);
    key_ev(1'b0, 9'h04D);
    step(); step(); step();
    chk("pause_release", 32'(pause_req), 32'h0);

    // Random traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      reset_n = ($urandom_range(0, 299) != 0);
      if ($urandom_range(0, 3) == 0) joy = $urandom;
      if ($urandom_range(0, 15) == 0) cabinet = ~cabinet;
      if ($urandom_range(0, 2) == 0)
        key_ev(1'($urandom_range(0, 1)), {1'($urandom_range(0, 1)), codes[$urandom_range(0, 24)]});
      step();
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
